// File: rtl/vcd_n_ud.sv
// vcd_n_ud: N-digit BCD up/down counter with parallel load, synchronous
// clear, wrap/saturate mode and decade-chain cascade outputs (tc/ceo).
module vcd_n_ud #(
    parameter int unsigned DIGITS   = 4,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rn,
    input  logic                  ce,
    input  logic                  r,
    input  logic                  up,
    input  logic                  ld,
    input  logic [4*DIGITS-1:0]   d,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  ceo,
    output logic                  ovf,
    output logic                  ld_err
);

    logic [4*DIGITS-1:0] q_step;
    logic [4*DIGITS-1:0] d_clamp;
    logic                clamp_any;
    logic                all_nine;
    logic                all_zero;

    // Terminal-count detection: all digits at 9 (up) or all at 0 (down).
    always_comb begin
        all_nine = 1'b1;
        all_zero = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (q[4*i +: 4] != 4'd9) all_nine = 1'b0;
            if (q[4*i +: 4] != 4'd0) all_zero = 1'b0;
        end
    end

    assign tc  = up ? all_nine : all_zero;
    assign ceo = ce & tc;

    // Clamp every load nibble above 9 down to 9 and flag it.
    always_comb begin
        d_clamp   = d;
        clamp_any = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (d[4*i +: 4] > 4'd9) begin
                d_clamp[4*i +: 4] = 4'd9;
                clamp_any         = 1'b1;
            end
        end
    end

    // Ripple the carry/borrow through the digits; at terminal count this
    // naturally produces the wrapped value (all 0s up, all 9s down).
    always_comb begin
        logic carry;
        q_step = q;
        carry  = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (up) begin
                    if (q[4*i +: 4] == 4'd9) begin
                        q_step[4*i +: 4] = 4'd0;
                    end else begin
                        q_step[4*i +: 4] = q[4*i +: 4] + 4'd1;
                        carry            = 1'b0;
                    end
                end else begin
                    if (q[4*i +: 4] == 4'd0) begin
                        q_step[4*i +: 4] = 4'd9;
                    end else begin
                        q_step[4*i +: 4] = q[4*i +: 4] - 4'd1;
                        carry            = 1'b0;
                    end
                end
            end
        end
    end

    // Count register with priority clear > load > count > hold.
    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            q      <= '0;
            ovf    <= 1'b0;
            ld_err <= 1'b0;
        end else if (r) begin
            q      <= '0;
            ovf    <= 1'b0;
            ld_err <= 1'b0;
        end else if (ld) begin
            q      <= d_clamp;
            ovf    <= 1'b0;
            ld_err <= clamp_any;
        end else if (ce) begin
            ovf    <= tc;
            ld_err <= 1'b0;
            if (!(tc && SATURATE)) q <= q_step;
        end else begin
            ovf    <= 1'b0;
            ld_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vcd_n_ud.sv
// tb_vcd_n_ud: scoreboard bench for vcd_n_ud (wrap and saturate variants,
// plus a two-stage DIGITS=2 cascade against a DIGITS=4 instance).
module tb_vcd_n_ud;

    typedef struct {
        logic [15:0] qw;
        logic        ovw;
        logic        lew;
        logic [15:0] qs;
        logic        ovs;
        logic        les;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rn, ce, r, up, ld;
    logic [15:0] d;
    logic [15:0] qw, qs;
    logic        tcw, ceow, ovw, lew;
    logic        tcs, ceos, ovs, les;

    // cascade signals
    logic        c_ce;
    logic [7:0]  c0_q, c1_q;
    logic        c0_tc, c0_ceo, c0_ovf, c0_le;
    logic        c1_tc, c1_ceo, c1_ovf, c1_le;
    logic [15:0] r4_q;
    logic        r4_tc, r4_ceo, r4_ovf, r4_le;

    vcd_n_ud #(.DIGITS(4), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rn(rn), .ce(ce), .r(r), .up(up), .ld(ld), .d(d),
        .q(qw), .tc(tcw), .ceo(ceow), .ovf(ovw), .ld_err(lew));

    vcd_n_ud #(.DIGITS(4), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rn(rn), .ce(ce), .r(r), .up(up), .ld(ld), .d(d),
        .q(qs), .tc(tcs), .ceo(ceos), .ovf(ovs), .ld_err(les));

    vcd_n_ud #(.DIGITS(2), .SATURATE(1'b0)) u_c0 (
        .clk(clk), .rn(rn), .ce(c_ce), .r(1'b0), .up(1'b1), .ld(1'b0), .d(8'h00),
        .q(c0_q), .tc(c0_tc), .ceo(c0_ceo), .ovf(c0_ovf), .ld_err(c0_le));

    vcd_n_ud #(.DIGITS(2), .SATURATE(1'b0)) u_c1 (
        .clk(clk), .rn(rn), .ce(c0_ceo), .r(1'b0), .up(1'b1), .ld(1'b0), .d(8'h00),
        .q(c1_q), .tc(c1_tc), .ceo(c1_ceo), .ovf(c1_ovf), .ld_err(c1_le));

    vcd_n_ud #(.DIGITS(4), .SATURATE(1'b0)) u_r4 (
        .clk(clk), .rn(rn), .ce(c_ce), .r(1'b0), .up(1'b1), .ld(1'b0), .d(16'h0000),
        .q(r4_q), .tc(r4_tc), .ceo(r4_ceo), .ovf(r4_ovf), .ld_err(r4_le));

    // Reference models hold the count as a plain integer 0..9999.
    int mw = 0;
    int ms = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] b;
        int t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            b[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return b;
    endfunction

    // Advance one integer model by one clock with the given inputs.
    task automatic model(inout int v, input bit sat, input logic ir, ild, ice, iup,
                         input logic [15:0] id, output logic o_ovf, output logic o_le);
        logic [15:0] c;
        int acc;
        o_ovf = 1'b0;
        o_le  = 1'b0;
        if (ir) begin
            v = 0;
        end else if (ild) begin
            c = id;
            acc = 0;
            for (int i = 3; i >= 0; i--) begin
                if (c[4*i +: 4] > 4'd9) begin
                    o_le = 1'b1;
                    acc = acc * 10 + 9;
                end else begin
                    acc = acc * 10 + int'(c[4*i +: 4]);
                end
            end
            v = acc;
        end else if (ice) begin
            if (iup) begin
                if (v == 9999) begin o_ovf = 1'b1; if (!sat) v = 0; end
                else v = v + 1;
            end else begin
                if (v == 0) begin o_ovf = 1'b1; if (!sat) v = 9999; end
                else v = v - 1;
            end
        end
    endtask

    // Drive one cycle of stimulus, check tc/ceo pre-edge, scoreboard q/ovf/ld_err post-edge.
    task automatic step(input logic ir, ild, ice, iup, input logic [15:0] id);
        exp_t e, g;
        logic o, l;
        r = ir; ld = ild; ce = ice; up = iup; d = id;
        #1;
        check("tc_wrap", {31'd0, tcw}, {31'd0, iup ? (mw == 9999) : (mw == 0)});
        check("ceo_wrap", {31'd0, ceow}, {31'd0, ice & (iup ? (mw == 9999) : (mw == 0))});
        check("tc_sat", {31'd0, tcs}, {31'd0, iup ? (ms == 9999) : (ms == 0)});
        model(mw, 1'b0, ir, ild, ice, iup, id, o, l);
        e.qw = to_bcd(mw); e.ovw = o; e.lew = l;
        model(ms, 1'b1, ir, ild, ice, iup, id, o, l);
        e.qs = to_bcd(ms); e.ovs = o; e.les = l;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check("q_wrap", {16'd0, qw}, {16'd0, g.qw});
        check("ovf_wrap", {31'd0, ovw}, {31'd0, g.ovw});
        check("lderr_wrap", {31'd0, lew}, {31'd0, g.lew});
        check("q_sat", {16'd0, qs}, {16'd0, g.qs});
        check("ovf_sat", {31'd0, ovs}, {31'd0, g.ovs});
        check("lderr_sat", {31'd0, les}, {31'd0, g.les});
    endtask

    initial begin
        exp_t e, g;
        rn = 1'b0; ce = 1'b0; r = 1'b0; up = 1'b1; ld = 1'b0; d = '0; c_ce = 1'b0;
        #3;
        check("rst_q", {16'd0, qw}, 32'd0);
        check("rst_ovf", {31'd0, ovw}, 32'd0);
        check("rst_lderr", {31'd0, lew}, 32'd0);
        @(posedge clk); #1;
        rn = 1'b1;

        // count to 0457 then assert reset mid-cycle
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0450);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        #2 rn = 1'b0;
        #1;
        check("async_rst_q", {16'd0, qw}, 32'd0);
        check("async_rst_q_sat", {16'd0, qs}, 32'd0);
        check("async_rst_ovf", {31'd0, ovw}, 32'd0);
        check("async_rst_lderr", {31'd0, lew}, 32'd0);
        mw = 0; ms = 0;
        #1 rn = 1'b1;
        @(posedge clk); #1;

        // up carry and wrap/saturate at 9999
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0999);
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h9998);
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);

        // down borrow and wrap/saturate at 0000
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h1000);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);

        // priority: clear beats load beats count
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234);
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'h1234);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);

        // load clamp
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'hA3F5);
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0123);

        // direction changes and mixed random traffic
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 3) != 0), 1'($urandom), 16'($urandom));
        end

        // cascade: two DIGITS=2 stages against one DIGITS=4 stage and an integer count
        c_ce = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            #1;
            check("cascade_ceo", {31'd0, c1_ceo}, {31'd0, (i % 10000) == 9999});
            e.qw = to_bcd((i + 1) % 10000);
            e.ovw = 1'b0; e.lew = 1'b0; e.qs = '0; e.ovs = 1'b0; e.les = 1'b0;
            sb.push_back(e);
            @(posedge clk); #1;
            g = sb.pop_front();
            check("cascade_q", {16'd0, c1_q, c0_q}, {16'd0, g.qw});
            check("cascade_ref4", {16'd0, r4_q}, {16'd0, g.qw});
        end
        c_ce = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
